capture_sequencer: RTL and testbench

- Captures the free-running event counter on each synchronized trigger edge and queues captures in a small FIFO.
- Drives the load/din side of the downstream 32-bit parallel-load shift register (`parshift`), one frame per capture, paced by its `done` flag.
- Also emits a frame-valid strobe aligned with the serial bits, for the downstream receiver.

---
 rtl/counter2_pkg.sv | 17 +
 rtl/cap_fifo.sv | 76 +++++++
 rtl/capture_sequencer.sv | 135 +++++++++++++
 tb/tb_capture_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter2_pkg.sv
// Shared definitions for the capture sequencer and the parallel-load shifter
// it feeds: sequencer state encoding and the common default frame width.
package counter2_pkg;

  // Default capture/frame width; the shifter instance must use the same value.
  localparam int DEFAULT_WIDTH = 32;

  // Default number of capture FIFO entries.
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/cap_fifo.sv
// Single-clock capture FIFO.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (pointers and level only)
//   push   : write wdata this edge (accepted when not full, or when full
//            and a pop happens on the same edge)
//   pop    : remove head this edge (ignored when empty)
//   wdata  : value to queue
//   head   : oldest queued value
//   level  : number of queued entries, 0..DEPTH
//   full   : level == DEPTH
//   empty  : level == 0
module cap_fifo
  import counter2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign head  = r_mem[r_rd];

  // A pop on the same edge frees the slot, so a push at full still lands.
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  // Storage carries no reset; only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: timestamps rising edges of an asynchronous trigger with
// the free-running counter, queues them, and plays each one out as a frame
// through a downstream parallel-load shift register.
//   clk        : rising-edge clock, shared with the shifter
//   rst_n      : asynchronous active-low reset
//   trig_in    : asynchronous trigger; a rising edge requests a capture
//   cnt_in     : free-running counter, synchronous to clk
//   done_in    : shifter done flag (bit 0 on sout)
//   load       : shifter load (1 = load/hold, 0 = shift)
//   din        : shifter parallel data
//   sframe     : high exactly while sout carries frame bits MSB..0
//   fifo_level : captures queued
//   overflow   : sticky; a capture was dropped because the FIFO was full
module capture_sequencer
  import counter2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        trig_in,
  input  logic [WIDTH-1:0]            cnt_in,
  input  logic                        done_in,
  output logic                        load,
  output logic [WIDTH-1:0]            din,
  output logic                        sframe,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
  output logic                        overflow
);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  seq_state_t       r_state;
  logic             r_load;
  logic [WIDTH-1:0] r_din;
  logic             r_sframe;
  logic             r_overflow;

  logic             w_rise;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_head;

  // Two flops resolve metastability; the third gives the edge reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= trig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_pop  = (r_state == IDLE) & ~w_empty;

  cap_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_rise),
    .pop   (w_pop),
    .wdata (cnt_in),
    .head  (w_head),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // A capture is lost only when full and no pop frees a slot on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_rise & w_full & ~w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // IDLE keeps the shifter reloading zero so sout idles low between frames.
  // The shifter samples din at the edge that ends LOAD; that same edge
  // raises sframe, which drops on the edge after done_in shows bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_load   <= 1'b1;
      r_din    <= '0;
      r_sframe <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_load <= 1'b1;
          if (w_pop) begin
            r_din   <= w_head;
            r_state <= LOAD;
          end else begin
            r_din <= '0;
          end
        end
        LOAD: begin
          r_load   <= 1'b0;
          r_sframe <= 1'b1;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          if (done_in) begin
            r_load   <= 1'b1;
            r_din    <= '0;
            r_sframe <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_load   <= 1'b1;
          r_din    <= '0;
          r_sframe <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign load     = r_load;
  assign din      = r_din;
  assign sframe   = r_sframe;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;
  import counter2_pkg::*;

  localparam int W  = DEFAULT_WIDTH;
  localparam int D  = 4;
  localparam int LW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          trig_in = 1'b0;
  logic [W-1:0]  cnt_in = '0;
  logic          done_in;
  logic          done_force = 1'b0;
  logic          load;
  logic [W-1:0]  din;
  logic          sframe;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  always #5 clk = ~clk;

  capture_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig_in    (trig_in),
    .cnt_in     (cnt_in),
    .done_in    (done_in),
    .load       (load),
    .din        (din),
    .sframe     (sframe),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  // Behavioural model of the downstream parshift: load or shift left, MSB out,
  // done when W-1 shifts have happened since the last load.
  logic [W-1:0] sh_r = '0;
  int           sh_cnt = 0;
  logic         sout;
  always @(posedge clk) begin
    if (load) begin
      sh_r   <= din;
      sh_cnt <= 0;
    end else begin
      sh_r   <= {sh_r[W-2:0], 1'b0};
      sh_cnt <= sh_cnt + 1;
    end
  end
  assign sout    = sh_r[W-1];
  assign done_in = (sh_cnt == W-1) | done_force;

  // Frame receiver: collects sout while sframe is high.
  int           cyc = 0;
  logic [W-1:0] acc = '0;
  int           nb = 0;
  logic         sf_q = 1'b0;
  int           gap_err = 0;
  bit           gap_en = 1'b0;
  int           aborted = 0;
  logic [W-1:0] got_q[$];
  int           start_q[$];
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sframe) begin
      acc <= sf_q ? {acc[W-2:0], sout} : {{(W-1){1'b0}}, sout};
      nb  <= sf_q ? nb + 1 : 1;
      if (!sf_q) start_q.push_back(cyc);
    end else begin
      if (sf_q) begin
        if (nb == W) got_q.push_back(acc);
        else aborted <= aborted + 1;
      end
      if (gap_en && sout) gap_err <= gap_err + 1;
    end
    sf_q <= sframe;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle trigger pulse; returns #1 after the edge that pushes the FIFO.
  task automatic pulse(input logic [W-1:0] v);
    trig_in = 1'b1;
    cnt_in  = v;
    @(posedge clk); #1 trig_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  // Returns #1 after the edge that raises sframe (E0).
  task automatic wait_frame_start(input string tag);
    int k = 0;
    while (!sframe && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!sframe) check({tag, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (got_q.size() < n && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_nframes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_frame%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_load", load, 1);
    check("rst_din", din, 0);
    check("rst_sframe", sframe, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single trigger: latency, pop, frame contents.
    trig_in = 1'b1;
    cnt_in  = 32'hA5A5_0001;
    @(posedge clk); #1 trig_in = 1'b0;
    @(posedge clk); #1 check("t1_level_before_push", fifo_level, 0);
    @(posedge clk); #1 check("t1_level_after_push", fifo_level, 1);
    @(posedge clk); #1;
    check("t1_level_popped", fifo_level, 0);
    check("t1_load_in_load", load, 1);
    check("t1_din_in_load", din, 32'hA5A5_0001);
    @(posedge clk); #1;
    check("t1_sframe_e0", sframe, 1);
    check("t1_load_shift", load, 0);
    exp_q.push_back(32'hA5A5_0001);
    wait_frames(1);
    check("t1_overflow", overflow, 0);
    check("t1_level_end", fifo_level, 0);
    compare_frames("t1");

    // Three triggers three cycles apart: order and minimum frame period.
    pulse(32'd1);
    pulse(32'd2);
    pulse(32'd3);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd3);
    wait_frames(3);
    check("t2_period_a", start_q[1] - start_q[0], W + 2);
    check("t2_period_b", start_q[2] - start_q[1], W + 2);
    compare_frames("t2");

    // Full FIFO with a capture landing on the IDLE pop edge.
    pulse(32'h0000_1000);
    wait_frame_start("t3");
    pulse(32'h0000_1001);
    pulse(32'h0000_1002);
    pulse(32'h0000_1003);
    pulse(32'h0000_1004);
    check("t3_level_full", fifo_level, 4);
    repeat (18) @(posedge clk);
    #1;
    pulse(32'h0000_1005);
    check("t3_level_push_pop", fifo_level, 4);
    check("t3_no_overflow", overflow, 0);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h0000_1000 + i);
    wait_frames(6);
    compare_frames("t3");

    // Six triggers inside one frame: four queued, two dropped.
    pulse(32'h0000_2000);
    wait_frame_start("t4");
    for (int i = 1; i <= 6; i++) pulse(32'h0000_2000 + i);
    check("t4_level_full", fifo_level, 4);
    check("t4_overflow_set", overflow, 1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h0000_2000 + i);
    wait_frames(5);
    repeat (2 * (W + 2)) @(posedge clk);
    #1;
    check("t4_overflow_sticky", overflow, 1);
    check("t4_level_end", fifo_level, 0);
    compare_frames("t4");

    // Reset in the middle of a frame.
    aborted = 0;
    pulse(32'h0000_3000);
    wait_frame_start("t5");
    pulse(32'h0000_3001);
    check("t5_level_queued", fifo_level, 1);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_load", load, 1);
    check("t5_din", din, 0);
    check("t5_sframe", sframe, 0);
    check("t5_level", fifo_level, 0);
    check("t5_overflow", overflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_sout_idle", sout, 0);
    check("t5_aborted", aborted, 1);
    got_q.delete();
    start_q.delete();
    pulse(32'h0000_3002);
    exp_q.push_back(32'h0000_3002);
    wait_frames(1);
    compare_frames("t5");

    // Boundary values, idle sout, done_in ignored outside SHIFT.
    aborted = 0;
    gap_en  = 1'b1;
    done_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_load", load, 1);
    check("t6_idle_sframe", sframe, 0);
    done_force = 1'b0;
    pulse(32'hFFFF_FFFF);
    pulse(32'h8000_0001);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h8000_0001);
    wait_frames(2);
    compare_frames("t6a");
    pulse(32'h1234_5678);
    done_force = 1'b1;
    repeat (2) @(posedge clk);
    #1 done_force = 1'b0;
    check("t6_sframe_after_load", sframe, 1);
    exp_q.push_back(32'h1234_5678);
    wait_frames(1);
    compare_frames("t6b");
    check("t6_gap_zero", gap_err, 0);
    check("t6_aborted", aborted, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
